// File: rtl/athos_pkg.sv
// athos_pkg
// Shared definitions for the CBD3 unpacking datapath.
//   CBD3_Q       - modulus used when folding negative coefficients into 0..q-1
//   coef_t       - 16-bit coefficient word as seen on the output bus
//   cbd3_state_t - polynomial sequencing states (IDLE / RUN / DONE)
package athos_pkg;

  localparam int CBD3_Q = 3329;

  typedef logic [15:0] coef_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cbd3_state_t;

endpackage

// File: rtl/cbd3_coef_calc.sv
// cbd3_coef_calc
// Turns one 6-bit packed group into a coefficient: a = grp[2:0], b = grp[5:3],
// result = a - b as a 4-bit signed value, sign-extended to 16 bits.
// Configuration macro: ATHOS_CBD3_MODQ_EN -- when defined, negative results
// are folded to result + CBD3_Q so the output lies in 0..CBD3_Q-1.
// Ports:
//   grp     in  6   packed group {b, a}
//   coef    out 16  coefficient value
//   illegal out 1   a or b exceeds 3 (not a valid 3-bit popcount of 3 bits)
module cbd3_coef_calc
  import athos_pkg::*;
(
  input  logic [5:0] grp,
  output coef_t      coef,
  output logic       illegal
);

  logic [2:0]        a;
  logic [2:0]        b;
  logic signed [3:0] diff;
  coef_t             diff_ext;

  assign a        = grp[2:0];
  assign b        = grp[5:3];
  // Zero-extend both fields by one bit so 0..7 minus 0..7 fits in 4-bit signed.
  assign diff     = signed'({1'b0, a}) - signed'({1'b0, b});
  assign diff_ext = {{12{diff[3]}}, diff};
  // A popcount of three bits can never exceed 3, so the top bit flags garbage.
  assign illegal  = a[2] | b[2];

`ifdef ATHOS_CBD3_MODQ_EN
  // 16-bit wraparound add: (x + 2^16) + q == x + q for the negative range.
  assign coef = diff[3] ? coef_t'(diff_ext + coef_t'(CBD3_Q)) : diff_ext;
`else
  assign coef = diff_ext;
`endif

endmodule

// File: rtl/cbd3_unpack.sv
// cbd3_unpack
// Accepts 24-bit packed words (four 6-bit groups) and streams one signed
// coefficient per group with a valid/ready handshake, tagged with its index.
// Configuration macro: ATHOS_CBD3_MODQ_EN (see cbd3_coef_calc).
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i                begin a new polynomial (honoured only in IDLE)
//   word_valid_i/ready_o   packed word handshake, word_i carries the data
//   coef_valid_o/ready_i   coefficient handshake, coef_o / coef_idx_o payload
//   busy_o                 polynomial in progress (RUN or DONE)
//   done_o                 single-cycle completion pulse
//   err_o                  sticky illegal-field flag, cleared by accepted start
module cbd3_unpack
  import athos_pkg::*;
#(
  parameter int N_COEFF = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic [23:0] word_i,
  output logic        coef_valid_o,
  input  logic        coef_ready_i,
  output logic [15:0] coef_o,
  output logic [7:0]  coef_idx_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int N_WORDS = N_COEFF / 4;

  cbd3_state_t state, state_next;

  logic [23:0] buf_word;
  logic        buf_valid;
  logic [1:0]  j;
  logic [7:0]  idx;
  logic [7:0]  word_cnt;
  logic        err;

  logic [5:0]  grp;
  coef_t       calc_coef;
  logic        calc_illegal;
  logic        coef_fire;
  logic        word_fire;
  logic        last_fire;

  // Select the group currently being offered downstream.
  always_comb begin
    grp = buf_word[5:0];
    case (j)
      2'd0: grp = buf_word[5:0];
      2'd1: grp = buf_word[11:6];
      2'd2: grp = buf_word[17:12];
      2'd3: grp = buf_word[23:18];
      default: grp = buf_word[5:0];
    endcase
  end

  cbd3_coef_calc u_calc (
    .grp     (grp),
    .coef    (calc_coef),
    .illegal (calc_illegal)
  );

  assign coef_fire = buf_valid & coef_ready_i;
  assign last_fire = coef_fire && (idx == 8'(N_COEFF - 1));
  assign word_fire = word_valid_i & word_ready_o;

  // Next-state and control outputs. A new word may land in the same cycle the
  // last group of the current one is taken, which keeps one coefficient per
  // cycle on back-to-back words.
  always_comb begin
    state_next   = state;
    word_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_next = RUN;
      end
      RUN: begin
        busy_o       = 1'b1;
        word_ready_o = (word_cnt < 8'(N_WORDS)) &&
                       (!buf_valid || (j == 2'd3 && coef_ready_i));
        if (last_fire) state_next = DONE;
      end
      DONE: begin
        busy_o     = 1'b1;
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus the word buffer, group pointer and counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      buf_word  <= '0;
      buf_valid <= 1'b0;
      j         <= 2'd0;
      idx       <= 8'd0;
      word_cnt  <= 8'd0;
      err       <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start_i) begin
        buf_valid <= 1'b0;
        j         <= 2'd0;
        idx       <= 8'd0;
        word_cnt  <= 8'd0;
        err       <= 1'b0;
      end else begin
        if (coef_fire) begin
          j   <= j + 2'd1;
          idx <= idx + 8'd1;
          if (calc_illegal) err <= 1'b1;
        end
        if (word_fire) begin
          buf_word  <= word_i;
          buf_valid <= 1'b1;
          word_cnt  <= word_cnt + 8'd1;
        end else if (coef_fire && j == 2'd3) begin
          buf_valid <= 1'b0;
        end
      end
    end
  end

  assign coef_valid_o = buf_valid;
  assign coef_o       = buf_valid ? calc_coef : 16'd0;
  assign coef_idx_o   = idx;
  assign err_o        = err;

endmodule

// File: tb/tb_cbd3_unpack.sv
// tb_cbd3_unpack
// Directed and randomized bench for cbd3_unpack. A scoreboard of expected
// coefficients is filled from every accepted word using plain arithmetic and
// drained on every coefficient handshake. Honours ATHOS_CBD3_MODQ_EN.
`timescale 1ns/1ps
module tb_cbd3_unpack;
  import athos_pkg::*;

  localparam int N_COEFF = 256;
  localparam int N_WORDS = N_COEFF / 4;

  logic        clk = 1'b0;
  logic        rst, start, word_valid, word_ready, coef_valid, coef_ready;
  logic        busy, done, err;
  logic [23:0] word;
  logic [15:0] coef;
  logic [7:0]  coef_idx;

  always #5 clk = ~clk;

  cbd3_unpack #(.N_COEFF(N_COEFF)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .word_valid_i (word_valid),
    .word_ready_o (word_ready),
    .word_i       (word),
    .coef_valid_o (coef_valid),
    .coef_ready_i (coef_ready),
    .coef_o       (coef),
    .coef_idx_o   (coef_idx),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  int          n_compared = 0;
  int          n_mismatched = 0;
  logic [23:0] send_q[$];
  logic [15:0] exp_coef_q[$];
  bit          exp_ill_q[$];
  int          exp_idx = 0;
  bit          exp_err = 1'b0;
  bit          idle_expected = 1'b1;
  int          accepted = 0;
  int          cycle = 0;
  int          done_cnt = 0;
  int          done_cycle = -1;
  int          first_hs = -1;
  int          last_hs = -1;
  int          first_acc = -1;
  logic [15:0] obs_coef [N_COEFF];

  // Reference value of group g of word w, straight from a - b.
  function automatic logic [15:0] model_coef(logic [23:0] w, int g);
    int a, b, d;
    a = int'((w >> (6 * g)) & 24'h7);
    b = int'((w >> (6 * g + 3)) & 24'h7);
    d = a - b;
`ifdef ATHOS_CBD3_MODQ_EN
    if (d < 0) d = d + CBD3_Q;
`endif
    return 16'(d);
  endfunction

  function automatic bit model_illegal(logic [23:0] w, int g);
    int a, b;
    a = int'((w >> (6 * g)) & 24'h7);
    b = int'((w >> (6 * g + 3)) & 24'h7);
    return (a > 3) || (b > 3);
  endfunction

  function automatic logic [23:0] legal_word();
    logic [23:0] w;
    w = '0;
    for (int g = 0; g < 8; g++) w = w | (24'($urandom_range(0, 3)) << (3 * g));
    return w;
  endfunction

  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic apply_stimulus(bit do_rst, bit do_start, bit rdy);
    bit next_err;
    rst        = do_rst;
    start      = do_start;
    coef_ready = rdy;
    word_valid = (send_q.size() > 0);
    word       = word_valid ? send_q[0] : 24'h0;
    #1;
    next_err = exp_err;
    if (!do_rst) begin
      check_output("coef_valid", coef_valid, exp_coef_q.size() != 0);
      if (coef_valid && exp_coef_q.size() != 0) begin
        check_output("coef", coef, exp_coef_q[0]);
        check_output("coef_idx", coef_idx, exp_idx);
        if (rdy) begin
          obs_coef[exp_idx % N_COEFF] = coef;
          if (exp_idx == 0) first_hs = cycle;
          if (exp_idx == N_COEFF - 1) last_hs = cycle;
          if (exp_ill_q[0]) next_err = 1'b1;
          void'(exp_coef_q.pop_front());
          void'(exp_ill_q.pop_front());
          exp_idx++;
        end else begin
          check_output("word_ready_stall", word_ready, 0);
        end
      end
      check_output("err", err, exp_err);
      if (accepted >= N_WORDS) check_output("word_ready_limit", word_ready, 0);
      if (done) begin
        done_cnt++;
        done_cycle = cycle;
      end
      if (word_valid && word_ready) begin
        if (accepted == 0) first_acc = cycle;
        accepted++;
        for (int g = 0; g < 4; g++) begin
          exp_coef_q.push_back(model_coef(send_q[0], g));
          exp_ill_q.push_back(model_illegal(send_q[0], g));
        end
        void'(send_q.pop_front());
      end
      if (do_start && idle_expected) begin
        next_err      = 1'b0;
        exp_idx       = 0;
        accepted      = 0;
        done_cnt      = 0;
        idle_expected = 1'b0;
      end
      if (done) idle_expected = 1'b1;
      exp_err = next_err;
    end else begin
      send_q.delete();
      exp_coef_q.delete();
      exp_ill_q.delete();
      exp_idx       = 0;
      exp_err       = 1'b0;
      accepted      = 0;
      idle_expected = 1'b1;
    end
    cycle++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic check_idle_outputs(string tag);
    check_output({tag, "_word_ready"}, word_ready, 0);
    check_output({tag, "_coef_valid"}, coef_valid, 0);
    check_output({tag, "_coef"}, coef, 0);
    check_output({tag, "_coef_idx"}, coef_idx, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_err"}, err, 0);
  endtask

  // kind 0: until done seen; kind 1: until exp_idx reaches target.
  task automatic run_until(int kind, int target, int pct, int max_cycles);
    bit met;
    met = 1'b0;
    for (int i = 0; i < max_cycles && !met; i++) begin
      apply_stimulus(1'b0, 1'b0, $urandom_range(0, 99) < pct);
      met = (kind == 0) ? (done_cnt > 0) : (exp_idx >= target);
    end
    check_output("run_bound", met, 1);
  endtask

  initial begin
    logic [15:0] neg3;
`ifdef ATHOS_CBD3_MODQ_EN
    neg3 = 16'h0CFE;
`else
    neg3 = 16'hFFFD;
`endif
    rst = 1'b1; start = 1'b0; word_valid = 1'b0; word = '0; coef_ready = 1'b0;
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_idle_outputs("reset");

    // Polynomial A: zero/sign words then legal random words, full rate,
    // with one surplus word that must never be taken.
    send_q.push_back(24'h000000);
    send_q.push_back(24'h000003);
    send_q.push_back(24'h000018);
    for (int i = 3; i < N_WORDS + 1; i++) send_q.push_back(legal_word());
    first_acc = -1;
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check_output("busy_after_start", busy, 1);
    run_until(0, 0, 100, 600);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("done_once", done_cnt, 1);
    check_output("done_after_last", done_cycle, last_hs + 1);
    check_output("stream_consecutive", last_hs - first_hs, N_COEFF - 1);
    check_output("first_coef_latency", first_hs, first_acc + 1);
    check_output("extra_word_left", send_q.size(), 1);
    check_output("busy_idle", busy, 0);
    for (int i = 0; i < 4; i++) check_output("zero_word", obs_coef[i], 0);
    check_output("sign_pos3", obs_coef[4], 16'h0003);
    for (int i = 5; i < 8; i++) check_output("sign_pos_rest", obs_coef[i], 0);
    check_output("sign_neg3", obs_coef[8], neg3);
    send_q.delete();

    // Polynomial B: illegal fields, a 5-cycle stall mid-word, random ready.
    send_q.push_back(24'h000004);
    send_q.push_back(24'h00003F);
    for (int i = 2; i < N_WORDS; i++) send_q.push_back(24'($urandom()));
    apply_stimulus(1'b0, 1'b1, 1'b1);
    run_until(1, 1, 100, 50);
    check_output("illegal_value", obs_coef[0], 16'h0004);
    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("err_rise", err, 1);
    run_until(1, 6, 100, 50);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("stall_no_progress", exp_idx, 6);
    run_until(0, 0, 70, 3000);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("done_once_b", done_cnt, 1);
    check_output("err_hold", err, 1);

    // Polynomial C: start clears err, a start mid-run is ignored, then reset.
    for (int i = 0; i < N_WORDS; i++) send_q.push_back(24'($urandom()));
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check_output("err_clear", err, 0);
    run_until(1, 50, 80, 500);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    run_until(1, 101, 80, 500);
    apply_stimulus(1'b1, 1'b0, 1'b1);
    check_idle_outputs("midreset");

    // Polynomial D: restart after reset begins at index 0.
    for (int i = 0; i < N_WORDS; i++) send_q.push_back(legal_word());
    apply_stimulus(1'b0, 1'b1, 1'b0);
    run_until(1, 0, 0, 1);
    for (int i = 0; i < 10 && !coef_valid; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
    check_output("restart_valid", coef_valid, 1);
    check_output("restart_idx0", coef_idx, 0);
    run_until(0, 0, 100, 600);
    check_output("done_once_d", done_cnt, 1);
    check_output("done_after_last_d", done_cycle, last_hs + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
